// File: rtl/exe_hazard_ctrl.sv
// EXE-stage pipeline controller: load-use stall, taken-branch redirect/flush, memory freeze.
// Optional perf counters are built only when HAZARD_PERF_CNT_EN is defined.
module exe_hazard_ctrl #(
  parameter int PC_SIZE        = 32,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_uses_rs2,
  input  logic [4:0]         ex_rd,
  input  logic               ex_mem_read,
  input  logic               ex_branch,
  input  logic               ex_zero,
  input  logic [PC_SIZE-1:0] ex_pc_jump,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               id_ex_write,
  output logic               id_ex_bubble,
  output logic               ex_mem_write,
  output logic               pc_sel,
  output logic [PC_SIZE-1:0] pc_target,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  if (LOAD_STALL_CYC < 1 || LOAD_STALL_CYC > 15) begin : g_bad_param
    $error("LOAD_STALL_CYC must be in 1..15");
  end

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic freeze;
  logic branch_taken;
  logic rd_match;
  logic load_use;
  logic stall_event;
  logic flush_event;

  assign freeze       = mem_req & ~mem_ready;
  // A stalled EXE holds a bubble, so its branch inputs are stale and must not redirect.
  assign branch_taken = (state_q == ST_RUN) & ex_branch & ex_zero;
  assign rd_match     = (ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2));
  assign load_use     = (state_q == ST_RUN) & ex_mem_read & (ex_rd != 5'd0) & rd_match;

  // NOTE: every output and next-state value gets a default before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pc_sel       = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_event  = 1'b0;
    flush_event  = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      state_d      = ST_RUN;
      cnt_d        = 4'd0;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (state_q == ST_STALL) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_event  = 1'b1;
      cnt_d        = cnt_q - 4'd1;
      if (cnt_q <= 4'd1) begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      pc_sel       = 1'b1;
      flush_event  = 1'b1;
    end else if (load_use) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      stall_event  = 1'b1;
      if (LOAD_STALL_CYC > 1) begin
        state_d = ST_STALL;
        cnt_d   = STALL_INIT;
      end
    end
  end

  assign pc_target = pc_sel ? ex_pc_jump : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters; stall_event/flush_event are already masked by rst and freeze.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_event && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_event && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic unused_events;
  assign unused_events = stall_event ^ flush_event;
  assign stall_cnt     = '0;
  assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_STALL_CYC=1 and =3) share directed stimulus;
// expected output classes are queued per cycle and compared by an independent monitor.
module tb_exe_hazard_ctrl;

  localparam int PC_SIZE = 32;
  localparam int CNT_W   = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef enum {K_RST, K_NORM, K_FRZ, K_BR, K_STL} kind_e;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs2;
    logic [4:0]  rd;
    logic        mem_read;
    logic        branch;
    logic        zero;
    logic [31:0] jump;
    logic        mem_req;
    logic        mem_ready;
  } stim_t;

  typedef struct {
    int          cyc;
    logic [38:0] exp_a;
    logic [38:0] exp_b;
    bit          cc;
    int          sa, fa, sb, fb;
  } exp_t;

  logic        clk = 1'b0;
  stim_t       s;
  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc_n = 0;

  logic              pcw_a, ifw_a, iff_a, idw_a, idb_a, exw_a, sel_a;
  logic              pcw_b, ifw_b, iff_b, idw_b, idb_b, exw_b, sel_b;
  logic [PC_SIZE-1:0] tgt_a, tgt_b;
  logic [CNT_W-1:0]   scnt_a, fcnt_a, scnt_b, fcnt_b;

  always #5 clk = ~clk;

  exe_hazard_ctrl #(.PC_SIZE(PC_SIZE), .LOAD_STALL_CYC(1), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(s.rst), .id_rs1(s.rs1), .id_rs2(s.rs2), .id_uses_rs2(s.uses_rs2),
    .ex_rd(s.rd), .ex_mem_read(s.mem_read), .ex_branch(s.branch), .ex_zero(s.zero),
    .ex_pc_jump(s.jump), .mem_req(s.mem_req), .mem_ready(s.mem_ready),
    .pc_write(pcw_a), .if_id_write(ifw_a), .if_id_flush(iff_a), .id_ex_write(idw_a),
    .id_ex_bubble(idb_a), .ex_mem_write(exw_a), .pc_sel(sel_a), .pc_target(tgt_a),
    .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

  exe_hazard_ctrl #(.PC_SIZE(PC_SIZE), .LOAD_STALL_CYC(3), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(s.rst), .id_rs1(s.rs1), .id_rs2(s.rs2), .id_uses_rs2(s.uses_rs2),
    .ex_rd(s.rd), .ex_mem_read(s.mem_read), .ex_branch(s.branch), .ex_zero(s.zero),
    .ex_pc_jump(s.jump), .mem_req(s.mem_req), .mem_ready(s.mem_ready),
    .pc_write(pcw_b), .if_id_write(ifw_b), .if_id_flush(iff_b), .id_ex_write(idw_b),
    .id_ex_bubble(idb_b), .ex_mem_write(exw_b), .pc_sel(sel_b), .pc_target(tgt_b),
    .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

  // Output bundle: {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush,
  //                 id_ex_bubble, pc_sel, pc_target}
  function automatic logic [38:0] exp_out(kind_e k, logic [31:0] jump);
    case (k)
      K_RST:   return {7'b0000_110, 32'h0};
      K_NORM:  return {7'b1111_000, 32'h0};
      K_FRZ:   return {7'b0000_000, 32'h0};
      K_BR:    return {7'b1111_111, jump};
      default: return {7'b0011_010, 32'h0};
    endcase
  endfunction

  function automatic stim_t s_idle();
    stim_t t = '0;
    t.mem_ready = 1'b1;
    return t;
  endfunction

  function automatic stim_t s_rst();
    stim_t t = s_idle();
    t.rst = 1'b1;
    return t;
  endfunction

  function automatic stim_t s_lu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic uses);
    stim_t t = s_idle();
    t.mem_read = 1'b1;
    t.rd       = rd;
    t.rs1      = rs1;
    t.rs2      = rs2;
    t.uses_rs2 = uses;
    return t;
  endfunction

  function automatic stim_t s_br(logic [31:0] jump, logic zero);
    stim_t t = s_idle();
    t.branch = 1'b1;
    t.zero   = zero;
    t.jump   = jump;
    return t;
  endfunction

  function automatic stim_t s_frz();
    stim_t t = s_idle();
    t.mem_req   = 1'b1;
    t.mem_ready = 1'b0;
    return t;
  endfunction

  task automatic check(string name, int c, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, c, act, req);
    end
  endtask

  // One clock of stimulus; counters (when cc) are the values expected during this cycle.
  task automatic cyc(stim_t v, kind_e ka, kind_e kb, bit cc = 1'b0,
                     int sa = 0, int fa = 0, int sbv = 0, int fb = 0);
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    e.cyc   = cyc_n;
    e.exp_a = exp_out(ka, v.jump);
    e.exp_b = exp_out(kb, v.jump);
    e.cc    = cc;
    e.sa    = PERF ? sa  : 0;
    e.fa    = PERF ? fa  : 0;
    e.sb    = PERF ? sbv : 0;
    e.fb    = PERF ? fb  : 0;
    sb_q.push_back(e);
    s = v;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("ctrl_a", e.cyc, 64'({pcw_a, ifw_a, idw_a, exw_a, iff_a, idb_a, sel_a, tgt_a}),
              64'(e.exp_a));
        check("ctrl_b", e.cyc, 64'({pcw_b, ifw_b, idw_b, exw_b, iff_b, idb_b, sel_b, tgt_b}),
              64'(e.exp_b));
        if (e.cc) begin
          check("stall_cnt_a", e.cyc, 64'(scnt_a), 64'(e.sa));
          check("flush_cnt_a", e.cyc, 64'(fcnt_a), 64'(e.fa));
          check("stall_cnt_b", e.cyc, 64'(scnt_b), 64'(e.sb));
          check("flush_cnt_b", e.cyc, 64'(fcnt_b), 64'(e.fb));
        end
      end
    end
  end

  initial begin : stimulus
    stim_t t;
    s = s_rst();
    // Reset, then free-running pipe.
    cyc(s_rst(), K_RST, K_RST);
    cyc(s_rst(), K_RST, K_RST);
    cyc(s_idle(), K_NORM, K_NORM);
    // rs1 load-use: 1 cycle on A, 3 cycles on B.
    cyc(s_lu(5'd5, 5'd5, 5'd0, 1'b0), K_STL, K_STL);
    cyc(s_idle(), K_NORM, K_STL);
    cyc(s_idle(), K_NORM, K_STL);
    cyc(s_idle(), K_NORM, K_NORM);
    // x0 destination never stalls.
    cyc(s_lu(5'd0, 5'd0, 5'd0, 1'b0), K_NORM, K_NORM);
    // rs2 load-use only when rs2 is actually read.
    cyc(s_lu(5'd7, 5'd3, 5'd7, 1'b1), K_STL, K_STL);
    cyc(s_idle(), K_NORM, K_STL);
    cyc(s_idle(), K_NORM, K_STL);
    cyc(s_idle(), K_NORM, K_NORM);
    cyc(s_lu(5'd7, 5'd3, 5'd7, 1'b0), K_NORM, K_NORM);
    // Taken / not-taken branch.
    cyc(s_br(32'h40, 1'b1), K_BR, K_BR);
    cyc(s_br(32'h40, 1'b0), K_NORM, K_NORM);
    // Branch and load-use together: branch wins.
    t = s_lu(5'd5, 5'd5, 5'd0, 1'b0);
    t.branch = 1'b1;
    t.zero   = 1'b1;
    t.jump   = 32'h80;
    cyc(t, K_BR, K_BR);
    // Load-use then two freeze cycles: B stalls 5 cycles total; branch ignored while stalled.
    cyc(s_lu(5'd9, 5'd9, 5'd0, 1'b0), K_STL, K_STL);
    cyc(s_frz(), K_FRZ, K_FRZ);
    cyc(s_frz(), K_FRZ, K_FRZ);
    cyc(s_br(32'h99, 1'b1), K_BR, K_STL);
    cyc(s_idle(), K_NORM, K_STL);
    cyc(s_idle(), K_NORM, K_NORM, 1'b1, 3, 3, 9, 2);
    // Memory request that completes this cycle does not freeze.
    t = s_idle();
    t.mem_req = 1'b1;
    cyc(t, K_NORM, K_NORM);
    // Reset in the middle of a stall aborts it.
    cyc(s_lu(5'd5, 5'd5, 5'd0, 1'b0), K_STL, K_STL);
    t = s_lu(5'd5, 5'd5, 5'd0, 1'b0);
    t.rst = 1'b1;
    cyc(t, K_RST, K_RST);
    cyc(s_idle(), K_NORM, K_NORM, 1'b1, 0, 0, 0, 0);
    cyc(s_idle(), K_NORM, K_NORM);
    // Twenty taken branches saturate a 4-bit flush counter.
    for (int i = 0; i < 20; i++) cyc(s_br(32'h100 + 32'(i * 4), 1'b1), K_BR, K_BR);
    cyc(s_idle(), K_NORM, K_NORM, 1'b1, 0, 15, 0, 15);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
